muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
- Parametrised N:1 data selector with a registered, flow-controlled output stage. Generalises the existing combinational 3:1 selector.
- Selection is decoded on input. The selected word passes through a 2-entry skid buffer with a valid/ready handshake.
- Used where ALU/memory/PC+4 result selection must cross a pipeline boundary, for example at the writeback stage of the pipelined core.

Parameters:
- N: default 32; data width in bits.
- NUM_IN: default 4; number of selectable inputs, legal range 2..16.
- SEL_W: default $clog2(NUM_IN); select width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  NUM_IN*N  packed inputs; input k occupies bits [k*N +: N]
- in_sel  input  SEL_W  index of the input to forward
- in_valid  input  1  in_data/in_sel are valid this cycle
- in_ready  output  1  block can accept a transfer this cycle
- out_data  output  N  selected word
- out_sel  output  SEL_W  index that produced out_data (tag)
- out_valid  output  1  out_data/out_sel are valid
- out_ready  input  1  consumer accepts this cycle
- sel_err  output  1  sticky out-of-range select flag (see Optional Feature)

Behaviour:
- Reset (async, on the reset rising edge, held while high): out_data=0, out_sel=0, out_valid=0, skid empty, in_ready=0 while reset is high, sel_err=0. in_ready goes to 1 on the first clk edge after reset deasserts.
- Accept: transfer on the clk edge where in_valid & in_ready. Drop: transfer on the clk edge where out_valid & out_ready.
- Decode: sel < NUM_IN forwards input sel. sel >= NUM_IN forwards all-zeros (matches the existing default-to-zero rule); out_sel still carries the raw sel.
- Latency: one cycle from accept to out_valid when the output register is empty or draining the same cycle.
- in_ready is a registered signal equal to !skid_valid. No combinational path exists from out_ready to in_ready.
- States, encoded as {main valid, skid valid}:
  - EMPTY: out_valid=0. Accept -> ONE.
  - ONE: out_valid=1. Accept with no drop -> FULL; the new word goes to skid. Accept with drop -> ONE; new word to main. Drop only -> EMPTY.
  - FULL: in_ready=0. Drop moves skid into main -> ONE. No drop -> hold.
- While out_valid=1 and out_ready=0, out_data/out_sel are stable. Word order is strictly FIFO; no word is ever lost or duplicated.
- in_valid while in_ready=0 is ignored; the producer must hold its data.
- Simultaneous accept and drop in ONE: throughput is one word per cycle.
- Reset mid-operation: all buffered words are discarded immediately. Outputs take reset values asynchronously.
- Undefined sel bits (X) are not filtered; the bench drives only known values.

Optional Feature:
- Macro MUXN_PIPE_SEL_ERR_EN.
- Defined: sel_err is set on any accept with in_sel >= NUM_IN and stays set until reset. The set takes effect on the accept edge.
- Not defined: sel_err is tied 0 and no error logic is synthesised. Data behaviour is identical in both builds.

Decomposition:
- Shared package riscv_mux_pkg holds:
  - default width constant XLEN=32
  - MUX_MAX_IN=16
  - a typedef for the 2-bit skid state encoding
- Sub-module pipe_skid_reg (parameter W) implements the 2-entry valid/ready skid buffer on the {sel, data} bundle.
- muxn_pipe holds the decode, error flag and one pipe_skid_reg instance.

Test Plan:
- Reset: assert reset mid-stream with a word in FULL -> out_valid=0, out_data=0, sel_err=0 immediately; in_ready=1 one edge after release.
- Streaming: NUM_IN=4, inputs 0x11111111/0x22222222/0x33333333/0x44444444, sel 0,1,2,3 back-to-back, out_ready=1 -> out_data follows in order one cycle later, in_ready stays 1.
- Backpressure: hold out_ready=0 and send sel=2 then sel=3:
  - expect out_data=0x33333333 held and in_ready=0 after the second accept
  - release -> next word 0x44444444, then in_ready=1
- Out of range: NUM_IN=3, sel=3 -> out_data=0, out_sel=3. With MUXN_PIPE_SEL_ERR_EN, sel_err=1 and stays 1 through 10 more legal transfers. Without the macro, sel_err=0.
- Random stress: random in_valid/out_ready, 10k cycles, N=8, NUM_IN=5 -> scoreboard shows order and count preserved. out_data is stable whenever out_valid & !out_ready.
- Width/depth sweep: N=64, NUM_IN=16, sel=15 with data 0xDEADBEEFCAFEF00D -> same value out after one cycle.

Source files
------------

// File: rtl/riscv_mux_pkg.sv
// Shared constants and types for the pipelined result selectors.
package riscv_mux_pkg;

  localparam int XLEN       = 32;
  localparam int MUX_MAX_IN = 16;

  // Encoded as {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer; in_ready is registered, so out_ready has
// no combinational path to in_ready.
module pipe_skid_reg
  import riscv_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         acc, drop;

  assign acc  = in_valid & rdy_q;
  assign drop = (state_q != SKID_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (acc) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (acc && !drop) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (acc && drop) begin
          main_d = in_data;
        end else if (drop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a drop can change anything.
        if (drop) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    rdy_d = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = main_q;
  assign out_valid = (state_q != SKID_EMPTY);

endmodule

// File: rtl/muxn_pipe.sv
// N:1 selector feeding a registered skid stage; out-of-range selects forward zero.
// Optional sticky select-error flag enabled by defining MUXN_PIPE_SEL_ERR_EN.
module muxn_pipe
  import riscv_mux_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sel_err
);

  logic [N-1:0]       sel_data;
  logic [SEL_W+N-1:0] bundle_in, bundle_out;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) sel_data = in_data[k*N +: N];
    end
  end

  // The raw select travels with the word as a tag, even when out of range.
  assign bundle_in = {in_sel, sel_data};

  pipe_skid_reg #(.W(SEL_W + N)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (bundle_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (bundle_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_sel  = bundle_out[SEL_W+N-1:N];
  assign out_data = bundle_out[N-1:0];

`ifdef MUXN_PIPE_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q;
    if (in_valid && in_ready && (int'(in_sel) >= NUM_IN)) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: directed cases on several configurations plus a
// randomized run on an 8-bit, 5-input instance against a queue model.
module tb_muxn_pipe;

`ifdef MUXN_PIPE_SEL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  // Instance A: N=32, NUM_IN=4
  logic [127:0] a_data;  logic [1:0] a_sel, a_os;  logic [31:0] a_od;
  logic a_iv, a_ir, a_ov, a_ordy, a_err;
  // Instance B: N=32, NUM_IN=3
  logic [95:0]  b_data;  logic [1:0] b_sel, b_os;  logic [31:0] b_od;
  logic b_iv, b_ir, b_ov, b_ordy, b_err;
  // Instance S: N=8, NUM_IN=5 (random stress)
  logic [39:0]  s_data;  logic [2:0] s_sel, s_os;  logic [7:0]  s_od;
  logic s_iv, s_ir, s_ov, s_ordy, s_err;
  // Instance C: N=64, NUM_IN=16
  logic [1023:0] c_data; logic [3:0] c_sel, c_os; logic [63:0] c_od;
  logic c_iv, c_ir, c_ov, c_ordy, c_err;

  muxn_pipe #(.N(32), .NUM_IN(4)) dut_a (
    .clk(clk), .reset(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_od), .out_sel(a_os), .out_valid(a_ov),
    .out_ready(a_ordy), .sel_err(a_err));

  muxn_pipe #(.N(32), .NUM_IN(3)) dut_b (
    .clk(clk), .reset(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_od), .out_sel(b_os), .out_valid(b_ov),
    .out_ready(b_ordy), .sel_err(b_err));

  muxn_pipe #(.N(8), .NUM_IN(5)) dut_s (
    .clk(clk), .reset(rst), .in_data(s_data), .in_sel(s_sel), .in_valid(s_iv),
    .in_ready(s_ir), .out_data(s_od), .out_sel(s_os), .out_valid(s_ov),
    .out_ready(s_ordy), .sel_err(s_err));

  muxn_pipe #(.N(64), .NUM_IN(16)) dut_c (
    .clk(clk), .reset(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_iv),
    .in_ready(c_ir), .out_data(c_od), .out_sel(c_os), .out_valid(c_ov),
    .out_ready(c_ordy), .sel_err(c_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of instance S: a queue of words in flight.
  logic [10:0] mq[$];
  logic        rdy_m = 1'b0;
  logic        err_m = 1'b0;
  logic        m_acc, m_drop;
  int          n_drop_m = 0;
  int          n_drop_dut = 0;
  logic        cmp_en = 1'b0;
  logic        hold_pend = 1'b0;
  logic [10:0] hold_val = '0;

  function automatic logic [7:0] exp_word(input logic [39:0] d, input logic [2:0] s);
    if (s < 3'd5) return d[int'(s)*8 +: 8];
    return 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      rdy_m = 1'b0;
      err_m = 1'b0;
    end else begin
      m_acc  = s_iv && rdy_m;
      m_drop = (mq.size() > 0) && s_ordy;
      if (m_drop) begin
        void'(mq.pop_front());
        n_drop_m++;
      end
      if (m_acc) begin
        mq.push_back({s_sel, exp_word(s_data, s_sel)});
        if (s_sel >= 3'd5 && ERR_EN) err_m = 1'b1;
      end
      rdy_m = (mq.size() < 2);
    end
  end

  // Pre-edge DUT observations: drops and whether the output must hold.
  always @(posedge clk) begin
    if (!rst) begin
      if (s_ov && s_ordy) n_drop_dut++;
      hold_pend = s_ov && !s_ordy;
      hold_val  = {s_os, s_od};
    end else begin
      hold_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("s_valid", 64'(s_ov), 64'(mq.size() > 0));
      chk("s_ready", 64'(s_ir), 64'(rdy_m));
      chk("s_err",   64'(s_err), 64'(err_m));
      if (s_ov && mq.size() > 0) begin
        chk("s_data", 64'(s_od), 64'(mq[0][7:0]));
        chk("s_sel",  64'(s_os), 64'(mq[0][10:8]));
      end
      if (hold_pend) chk("s_stable", 64'({s_os, s_od}), 64'(hold_val));
    end
  end

  task automatic run_a();
    a_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_sel = 2'(i);
      @(negedge clk);
      chk("stream_data",  64'(a_od), 64'(32'h11111111 * (i + 1)));
      chk("stream_sel",   64'(a_os), 64'(i));
      chk("stream_valid", 64'(a_ov), 64'd1);
      chk("stream_ready", 64'(a_ir), 64'd1);
    end
    a_iv = 1'b0;
    @(negedge clk);
    chk("stream_drain", 64'(a_ov), 64'd0);
    a_ordy = 1'b0; a_iv = 1'b1; a_sel = 2'd2;
    @(negedge clk);
    chk("bp_first", 64'(a_od), 64'h33333333);
    chk("bp_ready1", 64'(a_ir), 64'd1);
    a_sel = 2'd3;
    @(negedge clk);
    chk("bp_hold", 64'(a_od), 64'h33333333);
    chk("bp_full", 64'(a_ir), 64'd0);
    a_sel = 2'd1;  // must be ignored while in_ready is low
    @(negedge clk);
    chk("bp_hold2", 64'(a_od), 64'h33333333);
    chk("bp_hold2_sel", 64'(a_os), 64'd2);
    chk("bp_full2", 64'(a_ir), 64'd0);
    a_iv = 1'b0; a_ordy = 1'b1;
    @(negedge clk);
    chk("bp_next", 64'(a_od), 64'h44444444);
    chk("bp_next_sel", 64'(a_os), 64'd3);
    chk("bp_next_valid", 64'(a_ov), 64'd1);
    chk("bp_ready_back", 64'(a_ir), 64'd1);
    @(negedge clk);
    chk("bp_empty", 64'(a_ov), 64'd0);
  endtask

  task automatic run_b();
    b_data = {32'h33333333, 32'h22222222, 32'h11111111};
    b_ordy = 1'b1; b_iv = 1'b1; b_sel = 2'd3;
    @(negedge clk);
    chk("oor_data",  64'(b_od), 64'd0);
    chk("oor_sel",   64'(b_os), 64'd3);
    chk("oor_valid", 64'(b_ov), 64'd1);
    chk("oor_err",   64'(b_err), 64'(ERR_EN));
    for (int i = 0; i < 10; i++) begin
      b_sel = 2'(i % 3);
      @(negedge clk);
      chk("legal_data", 64'(b_od), 64'(32'h11111111 * ((i % 3) + 1)));
      chk("err_sticky", 64'(b_err), 64'(ERR_EN));
    end
    b_iv = 1'b0;
  endtask

  task automatic run_c();
    for (int k = 0; k < 16; k++) c_data[k*64 +: 64] = 64'(k) * 64'h0101010101010101;
    c_data[15*64 +: 64] = 64'hDEADBEEFCAFEF00D;
    c_ordy = 1'b1; c_iv = 1'b1; c_sel = 4'd15;
    @(negedge clk);
    chk("wide_data", c_od, 64'hDEADBEEFCAFEF00D);
    chk("wide_sel",  64'(c_os), 64'd15);
    c_sel = 4'd7;
    @(negedge clk);
    chk("wide_data7", c_od, 64'h0707070707070707);
    chk("wide_err", 64'(c_err), 64'd0);
    c_iv = 1'b0;
  endtask

  task automatic run_s();
    s_ordy = 1'b1; s_data = 40'h5544332211; s_sel = 3'd3; s_iv = 1'b1;
    @(negedge clk);
    chk("pin_model", 64'(mq[0]), 64'({3'd3, 8'h44}));
    chk("pin_dut",   64'(s_od), 64'h44);
    s_sel = 3'd6;
    @(negedge clk);
    chk("pin_model_oor", 64'(mq[0]), 64'({3'd6, 8'h00}));
    chk("pin_err", 64'(s_err), 64'(ERR_EN));
    for (int c = 0; c < 10000; c++) begin
      #1;
      if (!(s_iv && !s_ir)) begin
        s_iv   = 1'($urandom_range(0, 1));
        s_sel  = 3'($urandom_range(0, 7));
        s_data = {$urandom, 8'($urandom)};
      end
      s_ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    #1;
    s_iv = 1'b0; s_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("s_count", 64'(n_drop_dut), 64'(n_drop_m));
    chk("s_traffic", 64'(n_drop_m > 1000), 64'd1);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_data = '0; a_sel = '0; a_iv = 1'b0; a_ordy = 1'b0;
    b_data = '0; b_sel = '0; b_iv = 1'b0; b_ordy = 1'b0;
    s_data = '0; s_sel = '0; s_iv = 1'b0; s_ordy = 1'b0;
    c_data = '0; c_sel = '0; c_iv = 1'b0; c_ordy = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(a_ov), 64'd0);
    chk("rst_data",  64'(a_od), 64'd0);
    chk("rst_sel",   64'(a_os), 64'd0);
    chk("rst_ready", 64'(a_ir), 64'd0);
    chk("rst_err",   64'(b_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_pre", 64'(a_ir), 64'd0);
    @(negedge clk);
    chk("rel_ready", 64'(a_ir), 64'd1);
    cmp_en = 1'b1;

    fork
      run_s();
      begin
        run_a();
        run_b();
        run_c();
      end
    join

    // Reset while instance A is FULL; B carries a sticky error when enabled.
    a_ordy = 1'b0; a_iv = 1'b1; a_sel = 2'd0;
    @(negedge clk);
    a_sel = 2'd1;
    @(negedge clk);
    chk("mid_full", 64'(a_ir), 64'd0);
    chk("mid_valid", 64'(a_ov), 64'd1);
    a_iv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_ov), 64'd0);
    chk("mid_rst_data",  64'(a_od), 64'd0);
    chk("mid_rst_ready", 64'(a_ir), 64'd0);
    chk("mid_rst_err",   64'(b_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_pre", 64'(a_ir), 64'd0);
    @(negedge clk);
    chk("mid_rel_ready", 64'(a_ir), 64'd1);
    chk("mid_rel_valid", 64'(a_ov), 64'd0);
    chk("mid_rel_err",   64'(b_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
